// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: RAM geometry and the program loader state encoding.
package cpu_pkg;

    localparam int RAM_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RDY,
        HOLD,
        WAIT_DONE,
        FINISH,
        ERR
    } loader_state_e;

endpackage

// File: rtl/loader_image_mem.sv
// Program image store: flop array with one synchronous write port and one combinational read port.
module loader_image_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Contents deliberately survive reset so a reloaded image needs no rewrite.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_program_loader.sv
// Streams a stored program image into the CPU byte by byte, handshaking on the CPU's ready/done strobes.
module cpu_program_loader
    import cpu_pkg::*;
#(
    parameter int IMG_BYTES      = RAM_BYTES,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         img_we,
    input  logic [$clog2(IMG_BYTES)-1:0] img_addr,
    input  logic [7:0]                   img_wdata,
    input  logic                         start,
    output logic [7:0]                   prog_data,
    output logic                         programming,
    input  logic                         cpu_ready,
    input  logic                         cpu_done,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [4:0]                   bytes_sent,
    output loader_state_e                dbg_state
);

    localparam int IW = $clog2(IMG_BYTES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(IMG_BYTES - 1);
    localparam logic [4:0]    ALL_BYTES = 5'(IMG_BYTES);
    localparam logic [TW-1:0] TIMEOUT   = TW'(TIMEOUT_CYCLES);

    // Handshake: the CPU samples prog_data while programming=1 and signals consumption
    // with a rising edge on cpu_ready; the byte stays put until cpu_ready drops again.
    loader_state_e state;
    logic [IW-1:0] idx;
    logic [IW-1:0] rd_idx;
    logic [7:0]    rd_data;
    logic [TW-1:0] timer;
    logic          ready_q;
    logic          ready_rise;
    logic          timed_out;

    assign ready_rise = cpu_ready & ~ready_q;
    assign timed_out  = (timer == TIMEOUT);
    assign dbg_state  = state;

    // Read address is the index that will be current after this edge, so prog_data
    // can be registered in the same cycle idx moves.
    always_comb begin
        rd_idx = idx;
        if (state == IDLE) begin
            rd_idx = '0;
        end else if (state == HOLD && idx != LAST_IDX) begin
            rd_idx = idx + IW'(1);
        end
    end

    loader_image_mem #(
        .DEPTH(IMG_BYTES)
    ) u_image (
        .clk  (clk),
        .we   (img_we & ~busy),
        .waddr(img_addr),
        .wdata(img_wdata),
        .raddr(rd_idx),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            ready_q     <= 1'b0;
            prog_data   <= 8'h00;
            programming <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            bytes_sent  <= 5'd0;
        end else begin
            ready_q <= cpu_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ARM;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        bytes_sent  <= 5'd0;
                        idx         <= '0;
                        timer       <= '0;
                        programming <= 1'b1;
                        busy        <= 1'b1;
                        prog_data   <= rd_data;
                    end
                end
                ARM: begin
                    if (cpu_done) begin
                        state       <= FINISH;
                        programming <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        prog_data   <= 8'h00;
                    end else begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY, HOLD, WAIT_DONE: begin
                    // Completion beats timeout, timeout beats a same-cycle ready rise.
                    if (cpu_done) begin
                        state       <= FINISH;
                        programming <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        prog_data   <= 8'h00;
                    end else if (timed_out) begin
                        state       <= ERR;
                        programming <= 1'b0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        prog_data   <= 8'h00;
                    end else if (state == WAIT_RDY && ready_rise) begin
                        state      <= HOLD;
                        bytes_sent <= bytes_sent + 5'd1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                        if (state == HOLD && !cpu_ready) begin
                            if (bytes_sent == ALL_BYTES) begin
                                state <= WAIT_DONE;
                            end else begin
                                state     <= WAIT_RDY;
                                idx       <= rd_idx;
                                prog_data <= rd_data;
                            end
                        end
                    end
                end
                FINISH, ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: a simple CPU model consumes bytes and a scoreboard checks their order.
module tb_cpu_program_loader;
    import cpu_pkg::*;

    localparam int IMG  = 16;
    localparam int TMO  = 1023;

    logic          clk;
    logic          rst_n;
    logic          img_we;
    logic [3:0]    img_addr;
    logic [7:0]    img_wdata;
    logic          start;
    logic [7:0]    prog_data;
    logic          programming;
    logic          cpu_ready;
    logic          cpu_done;
    logic          busy;
    logic          done;
    logic          error;
    logic [4:0]    bytes_sent;
    loader_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] img_model [IMG];
    logic [7:0] exp_q [$];

    typedef struct {
        int         n_bytes;
        bit         settle;
        logic [4:0] exp_sent;
    } load_vec_t;

    load_vec_t vecs [5];

    cpu_program_loader #(
        .IMG_BYTES(IMG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_wdata  (img_wdata),
        .start      (start),
        .prog_data  (prog_data),
        .programming(programming),
        .cpu_ready  (cpu_ready),
        .cpu_done   (cpu_done),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bytes_sent (bytes_sent),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks: each is entered just after a negedge and returns just after a negedge
    task automatic write_img(input logic [3:0] addr, input logic [7:0] data);
        img_we    = 1'b1;
        img_addr  = addr;
        img_wdata = data;
        @(negedge clk);
        img_we = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        for (int i = 0; i < IMG; i++) exp_q.push_back(img_model[i]);
        @(negedge clk);
        start = 1'b0;
        check("arm_state", 32'(dbg_state), 32'(ARM));
        check("arm_prog", 32'(programming), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_err_clr", 32'(error), 32'd0);
        check("arm_done_clr", 32'(done), 32'd0);
        check("arm_sent_clr", 32'(bytes_sent), 32'd0);
    endtask

    // CPU model: ready rises 3 cycles after a byte appears and is held for `hold` cycles.
    task automatic cpu_byte(input int hold, input logic [4:0] exp_sent);
        logic [7:0] got;
        logic [7:0] exp;
        repeat (3) @(negedge clk);
        check("byte_prog", 32'(programming), 32'd1);
        got = prog_data;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_order: got %0h expected nothing (queue empty)", got);
        end else begin
            exp = exp_q.pop_front();
            check("byte_order", 32'(got), 32'(exp));
        end
        cpu_ready = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            check("byte_stable", 32'(prog_data), 32'(got));
        end
        check("bytes_sent", 32'(bytes_sent), 32'(exp_sent));
        cpu_ready = 1'b0;
    endtask

    task automatic finish_load(input bit settle, input logic [4:0] exp_sent);
        if (settle) @(negedge clk);
        check("pre_done_prog", 32'(programming), 32'd1);
        check("pre_done_flag", 32'(done), 32'd0);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        check("fin_state", 32'(dbg_state), 32'(FINISH));
        check("fin_done", 32'(done), 32'd1);
        check("fin_prog", 32'(programming), 32'd0);
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_error", 32'(error), 32'd0);
        check("fin_sent", 32'(bytes_sent), 32'(exp_sent));
        check("fin_data", 32'(prog_data), 32'd0);
        @(negedge clk);
        check("idle_state", 32'(dbg_state), 32'(IDLE));
        check("done_sticky", 32'(done), 32'd1);
        exp_q.delete();
    endtask

    task automatic run_load(input load_vec_t v);
        start_load();
        for (int i = 0; i < v.n_bytes; i++) cpu_byte(2, 5'(i + 1));
        finish_load(v.settle, v.exp_sent);
    endtask

    // main sequence
    initial begin
        vecs[0] = '{n_bytes: 16, settle: 1'b1, exp_sent: 5'd16};
        vecs[1] = '{n_bytes: 5,  settle: 1'b1, exp_sent: 5'd5};
        vecs[2] = '{n_bytes: 5,  settle: 1'b0, exp_sent: 5'd5};
        vecs[3] = '{n_bytes: 1,  settle: 1'b1, exp_sent: 5'd1};
        vecs[4] = '{n_bytes: 0,  settle: 1'b0, exp_sent: 5'd0};

        rst_n     = 1'b0;
        img_we    = 1'b0;
        img_addr  = 4'd0;
        img_wdata = 8'h00;
        start     = 1'b0;
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_data", 32'(prog_data), 32'd0);
        check("rst_prog", 32'(programming), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_sent", 32'(bytes_sent), 32'd0);

        for (int i = 0; i < IMG; i++) begin
            img_model[i] = 8'hA0 + 8'(i);
            write_img(4'(i), img_model[i]);
        end
        check("idle_data_zero", 32'(prog_data), 32'd0);

        for (int v = 0; v < 5; v++) run_load(vecs[v]);

        // CPU never answers: error lands TMO+2 cycles after the start edge
        start_load();
        repeat (TMO + 1) @(negedge clk);
        check("tmo_not_yet", 32'(error), 32'd0);
        check("tmo_prog_before", 32'(programming), 32'd1);
        @(negedge clk);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_state", 32'(dbg_state), 32'(ERR));
        check("tmo_prog", 32'(programming), 32'd0);
        check("tmo_done", 32'(done), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("tmo_idle", 32'(dbg_state), 32'(IDLE));
        check("tmo_sticky", 32'(error), 32'd1);
        exp_q.delete();

        // ready held for 10 cycles counts as one byte
        start_load();
        cpu_byte(10, 5'd1);
        finish_load(1'b1, 5'd1);

        // image write and start while busy are both ignored
        start_load();
        cpu_byte(2, 5'd1);
        cpu_byte(2, 5'd2);
        img_we    = 1'b1;
        img_addr  = 4'd3;
        img_wdata = 8'h55;
        start     = 1'b1;
        @(negedge clk);
        img_we = 1'b0;
        start  = 1'b0;
        check("busy_start_ignored", 32'(bytes_sent), 32'd2);
        for (int i = 2; i < IMG; i++) cpu_byte(2, 5'(i + 1));
        finish_load(1'b1, 5'd16);

        // async reset in the middle of byte 7, then a full reload from byte 0
        start_load();
        for (int i = 0; i < 7; i++) cpu_byte(2, 5'(i + 1));
        repeat (3) @(negedge clk);
        cpu_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_prog", 32'(programming), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_sent", 32'(bytes_sent), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        cpu_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
